// File: rtl/aes_block_sequencer_if.sv
// Core-side and stream-side bundle of the AES block sequencer.
// The master modport is the sequencer; the slave modport is the core/streamer environment.
interface aes_block_sequencer_if #(
  parameter int WORD_W = 32,
  parameter int BLK_W  = 128
);
  logic              core_ready_i;
  logic              core_done_i;
  logic [BLK_W-1:0]  core_result_i;
  logic              core_init_key_o;
  logic              core_start_o;
  logic [BLK_W-1:0]  core_block_o;
  logic              in_valid_i;
  logic [WORD_W-1:0] in_data_i;
  logic              in_ready_o;
  logic              out_valid_o;
  logic [WORD_W-1:0] out_data_o;
  logic              out_ready_i;

  modport master (
    input  core_ready_i, core_done_i, core_result_i,
    input  in_valid_i, in_data_i, out_ready_i,
    output core_init_key_o, core_start_o, core_block_o,
    output in_ready_o, out_valid_o, out_data_o
  );

  modport slave (
    output core_ready_i, core_done_i, core_result_i,
    output in_valid_i, in_data_i, out_ready_i,
    input  core_init_key_o, core_start_o, core_block_o,
    input  in_ready_o, out_valid_o, out_data_o
  );
endinterface

// File: rtl/aes_block_sequencer.sv
// Sequences one AES job: key init once, then per 128-bit block gather words,
// run the core and drain the result as words.
module aes_block_sequencer #(
  parameter int WORD_W = 32,
  parameter int BLK_W  = 128,
  parameter int LEN_W  = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  clear_i,
  input  logic                  start_i,
  input  logic [LEN_W-1:0]      data_len_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic [LEN_W-1:0]      blocks_done_o,
  aes_block_sequencer_if.master bus
);

  localparam int WORDS   = BLK_W / WORD_W;
  localparam int CNT_W   = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam int BYTE_SH = $clog2(BLK_W / 8);
  localparam logic [CNT_W-1:0] LAST_WORD = CNT_W'(WORDS - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_INIT_KEY, S_KEY_WAIT, S_LOAD, S_START, S_WAIT_CORE, S_SEND, S_FINISH
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [LEN_W-1:0]   nblk_q, nblk_d;
  logic [LEN_W-1:0]   blocks_done_q, blocks_done_d;
  logic [BLK_W-1:0]   block_q, block_d;
  logic [BLK_W-1:0]   result_q, result_d;
  logic               guard_q, guard_d;
  logic [LEN_W-1:0]   len_blocks;

  // Rounded-up block count; a partial tail still occupies a full padded block.
  assign len_blocks = (data_len_i >> BYTE_SH) + LEN_W'(|data_len_i[BYTE_SH-1:0]);

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_i) begin
    if (rst_i || clear_i) begin
      state_q       <= S_IDLE;
      cnt_q         <= '0;
      nblk_q        <= '0;
      blocks_done_q <= '0;
      block_q       <= '0;
      result_q      <= '0;
      guard_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      nblk_q        <= nblk_d;
      blocks_done_q <= blocks_done_d;
      block_q       <= block_d;
      result_q      <= result_d;
      guard_q       <= guard_d;
    end
  end

  // NOTE: every signal gets a default before the case so no latch is inferred.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    nblk_d        = nblk_q;
    blocks_done_d = blocks_done_q;
    block_d       = block_q;
    result_d      = result_q;
    guard_d       = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start_i) begin
          nblk_d        = len_blocks;
          blocks_done_d = '0;
          state_d       = (len_blocks == '0) ? S_FINISH : S_INIT_KEY;
        end
      end
      S_INIT_KEY: begin
        if (bus.core_ready_i) begin
          guard_d = 1'b1;
          state_d = S_KEY_WAIT;
        end
      end
      S_KEY_WAIT: begin
        // core_ready_i is not trusted in the cycle right after a pulse
        if (bus.core_ready_i && !guard_q) begin
          cnt_d   = '0;
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        if (bus.in_valid_i) begin
          block_d = {block_q[BLK_W-WORD_W-1:0], bus.in_data_i};
          cnt_d   = cnt_q + 1'b1;
          if (cnt_q == LAST_WORD) begin
            cnt_d   = '0;
            state_d = S_START;
          end
        end
      end
      S_START: begin
        if (bus.core_ready_i && !guard_q) begin
          guard_d = 1'b1;
          state_d = S_WAIT_CORE;
        end
      end
      S_WAIT_CORE: begin
        if (bus.core_done_i) begin
          result_d      = bus.core_result_i;
          blocks_done_d = blocks_done_q + 1'b1;
          cnt_d         = '0;
          state_d       = S_SEND;
        end
      end
      S_SEND: begin
        // result shifts left per accepted beat, so the head word is always the one presented
        if (bus.out_ready_i) begin
          result_d = {result_q[BLK_W-WORD_W-1:0], {WORD_W{1'b0}}};
          cnt_d    = cnt_q + 1'b1;
          if (cnt_q == LAST_WORD) begin
            cnt_d   = '0;
            state_d = (blocks_done_q < nblk_q) ? S_LOAD : S_FINISH;
          end
        end
      end
      S_FINISH: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_comb begin
    bus.core_init_key_o = (state_q == S_INIT_KEY) && bus.core_ready_i;
    bus.core_start_o    = (state_q == S_START) && bus.core_ready_i && !guard_q;
    bus.core_block_o    = block_q;
    bus.in_ready_o      = (state_q == S_LOAD);
    bus.out_valid_o     = (state_q == S_SEND);
    bus.out_data_o      = result_q[BLK_W-1 -: WORD_W];
    busy_o              = (state_q != S_IDLE);
    done_o              = (state_q == S_FINISH);
    blocks_done_o       = blocks_done_q;
  end

endmodule

// File: tb/tb_aes_block_sequencer.sv
// Directed bench for aes_block_sequencer with a behavioural AES core (result = block ^ mask),
// a word source and a word sink with optional back-pressure.
module tb_aes_block_sequencer;
  localparam int WORD_W = 32;
  localparam int BLK_W  = 128;
  localparam int LEN_W  = 32;

  logic             clk = 1'b0;
  logic             rst, clear, start;
  logic [LEN_W-1:0] data_len;
  logic             busy, done;
  logic [LEN_W-1:0] blocks_done;

  aes_block_sequencer_if #(.WORD_W(WORD_W), .BLK_W(BLK_W)) bus ();

  aes_block_sequencer #(.WORD_W(WORD_W), .BLK_W(BLK_W), .LEN_W(LEN_W)) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .clear_i       (clear),
    .start_i       (start),
    .data_len_i    (data_len),
    .busy_o        (busy),
    .done_o        (done),
    .blocks_done_o (blocks_done),
    .bus           (bus.master)
  );

  always #5 clk = ~clk;

  int          tests_run = 0;
  int          tests_failed = 0;
  logic [31:0] src_q[$];
  logic [31:0] out_q[$];
  logic [31:0] exp_w[8];
  bit          pend_in, toggle_mode, rdy_phase, stall_pend, in_ready_seen;
  logic [31:0] held;
  int          in_cnt, init_cnt, start_cnt, done_cnt, out_cnt;
  int          core_lat, lat_cnt, key_cnt;
  bit          start_seen, init_seen;
  logic [BLK_W-1:0] core_blk, xor_mask;

  task automatic check(input string tag, input logic [BLK_W-1:0] obs, input logic [BLK_W-1:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock of environment: drive at the falling edge, sample 1 ns later.
  task automatic step();
    @(negedge clk);
    bus.core_done_i = 1'b0;
    if (start_seen) begin
      bus.core_ready_i = 1'b0;
      lat_cnt          = core_lat;
      start_seen       = 1'b0;
    end else if (lat_cnt > 0) begin
      lat_cnt--;
      if (lat_cnt == 0) begin
        bus.core_done_i   = 1'b1;
        bus.core_result_i = core_blk ^ xor_mask;
        bus.core_ready_i  = 1'b1;
      end
    end
    if (init_seen) begin
      bus.core_ready_i = 1'b0;
      key_cnt          = 3;
      init_seen        = 1'b0;
    end else if (key_cnt > 0) begin
      key_cnt--;
      if (key_cnt == 0) bus.core_ready_i = 1'b1;
    end
    if (pend_in) begin
      void'(src_q.pop_front());
      in_cnt++;
    end
    if (src_q.size() > 0) begin
      bus.in_valid_i = 1'b1;
      bus.in_data_i  = src_q[0];
    end else begin
      bus.in_valid_i = 1'b0;
    end
    rdy_phase       = toggle_mode ? !rdy_phase : 1'b1;
    bus.out_ready_i = rdy_phase;
    #1;
    if (stall_pend) begin
      check("out_hold_valid", BLK_W'(bus.out_valid_o), 1);
      check("out_hold_data", BLK_W'(bus.out_data_o), BLK_W'(held));
    end
    stall_pend = 1'b0;
    if (bus.out_valid_o) begin
      if (bus.out_ready_i) begin
        out_q.push_back(bus.out_data_o);
        out_cnt++;
      end else begin
        stall_pend = 1'b1;
        held       = bus.out_data_o;
      end
    end
    pend_in   = bus.in_valid_i && bus.in_ready_o;
    init_cnt  += int'(bus.core_init_key_o);
    start_cnt += int'(bus.core_start_o);
    done_cnt  += int'(done);
    if (bus.in_ready_o) in_ready_seen = 1'b1;
    if (bus.core_init_key_o) init_seen = 1'b1;
    if (bus.core_start_o) begin
      start_seen = 1'b1;
      core_blk   = bus.core_block_o;
    end
  endtask

  task automatic clear_counts();
    in_cnt = 0; init_cnt = 0; start_cnt = 0; done_cnt = 0; out_cnt = 0;
    in_ready_seen = 1'b0;
    out_q.delete();
  endtask

  task automatic start_job(input logic [LEN_W-1:0] len);
    data_len = len;
    start    = 1'b1;
    step();
    start    = 1'b0;
  endtask

  task automatic wait_done(input int budget, input string tag);
    int n = 0;
    int d0 = done_cnt;
    while (done_cnt == d0 && n < budget) begin
      step();
      n++;
    end
    check({tag, "_done_seen"}, BLK_W'(done_cnt != d0), 1);
  endtask

  task automatic check_out(input string tag, input int n);
    check({tag, "_out_count"}, BLK_W'(out_q.size()), BLK_W'(n));
    for (int i = 0; i < n; i++) begin
      check($sformatf("%s_out_word%0d", tag, i),
            BLK_W'((i < out_q.size()) ? out_q[i] : 32'hDEAD_BEEF), BLK_W'(exp_w[i]));
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; clear = 1'b0; start = 1'b0; data_len = '0;
    bus.core_ready_i = 1'b1; bus.core_done_i = 1'b0; bus.core_result_i = '0;
    bus.in_valid_i = 1'b0; bus.in_data_i = '0; bus.out_ready_i = 1'b1;
    pend_in = 0; toggle_mode = 0; rdy_phase = 1; stall_pend = 0; held = '0;
    core_lat = 10; lat_cnt = 0; key_cnt = 0; start_seen = 0; init_seen = 0;
    core_blk = '0; xor_mask = '0;
    clear_counts();
    repeat (3) step();
    rst = 1'b0;
    step();

    check("rst_busy", BLK_W'(busy), 0);
    check("rst_done", BLK_W'(done), 0);
    check("rst_in_ready", BLK_W'(bus.in_ready_o), 0);
    check("rst_out_valid", BLK_W'(bus.out_valid_o), 0);
    check("rst_out_data", BLK_W'(bus.out_data_o), 0);
    check("rst_blocks_done", BLK_W'(blocks_done), 0);
    check("rst_core_block", bus.core_block_o, 0);
    check("rst_init_key", BLK_W'(bus.core_init_key_o), 0);
    check("rst_core_start", BLK_W'(bus.core_start_o), 0);

    // One block, core echoes after 10 cycles
    clear_counts();
    xor_mask = '0; core_lat = 10;
    exp_w[0] = 32'h0011_2233; exp_w[1] = 32'h4455_6677;
    exp_w[2] = 32'h8899_AABB; exp_w[3] = 32'hCCDD_EEFF;
    src_q = {exp_w[0], exp_w[1], exp_w[2], exp_w[3]};
    start_job(32'd16);
    check("t1_busy", BLK_W'(busy), 1);
    wait_done(200, "t1");
    repeat (3) step();
    check("t1_core_block", core_blk, 128'h00112233_44556677_8899AABB_CCDDEEFF);
    check("t1_init_pulses", BLK_W'(init_cnt), 1);
    check("t1_start_pulses", BLK_W'(start_cnt), 1);
    check("t1_done_cycles", BLK_W'(done_cnt), 1);
    check("t1_words_in", BLK_W'(in_cnt), 4);
    check_out("t1", 4);
    check("t1_blocks_done_held", BLK_W'(blocks_done), 1);
    check("t1_idle_busy", BLK_W'(busy), 0);

    // Two blocks with sink back-pressure, core result = block ^ A5..
    clear_counts();
    toggle_mode = 1'b1; xor_mask = {4{32'hA5A5_A5A5}}; core_lat = 3;
    src_q = {32'h1111_1111, 32'h2222_2222, 32'h3333_3333, 32'h4444_4444,
             32'h5555_5555, 32'h6666_6666, 32'h7777_7777, 32'h8888_8888};
    exp_w = '{32'hB4B4_B4B4, 32'h8787_8787, 32'h9696_9696, 32'hE1E1_E1E1,
              32'hF0F0_F0F0, 32'hC3C3_C3C3, 32'hD2D2_D2D2, 32'h2D2D_2D2D};
    start_job(32'd32);
    wait_done(400, "t2");
    step();
    toggle_mode = 1'b0;
    check("t2_init_pulses", BLK_W'(init_cnt), 1);
    check("t2_start_pulses", BLK_W'(start_cnt), 2);
    check("t2_done_cycles", BLK_W'(done_cnt), 1);
    check_out("t2", 8);
    check("t2_blocks_done", BLK_W'(blocks_done), 2);

    // Zero-length job
    clear_counts();
    start_job(32'd0);
    check("t3_done_pulse", BLK_W'(done), 1);
    check("t3_busy_finish", BLK_W'(busy), 1);
    step();
    check("t3_done_drop", BLK_W'(done), 0);
    check("t3_busy_idle", BLK_W'(busy), 0);
    check("t3_init_pulses", BLK_W'(init_cnt), 0);
    check("t3_start_pulses", BLK_W'(start_cnt), 0);
    check("t3_in_ready_seen", BLK_W'(in_ready_seen), 0);
    check("t3_blocks_done", BLK_W'(blocks_done), 0);

    // Partial tail: 20 bytes -> 2 blocks
    clear_counts();
    xor_mask = '0; core_lat = 1;
    exp_w = '{32'h0123_4567, 32'h89AB_CDEF, 32'hFEDC_BA98, 32'h7654_3210,
              32'h0F0F_0F0F, 32'hF0F0_F0F0, 32'h0000_0000, 32'hFFFF_FFFF};
    src_q = {exp_w[0], exp_w[1], exp_w[2], exp_w[3], exp_w[4], exp_w[5], exp_w[6], exp_w[7]};
    start_job(32'd20);
    wait_done(300, "t4");
    step();
    check("t4_words_in", BLK_W'(in_cnt), 8);
    check("t4_start_pulses", BLK_W'(start_cnt), 2);
    check("t4_done_cycles", BLK_W'(done_cnt), 1);
    check_out("t4", 8);
    check("t4_blocks_done", BLK_W'(blocks_done), 2);

    // Clear while the core is working, then a late core_done_i
    clear_counts();
    core_lat = 10;
    src_q = {32'h1, 32'h2, 32'h3, 32'h4};
    start_job(32'd16);
    for (int n = 0; n < 100 && start_cnt == 0; n++) step();
    check("t5_start_seen", BLK_W'(start_cnt), 1);
    repeat (2) step();
    clear = 1'b1;
    step();
    clear = 1'b0;
    check("t5_busy_after_clear", BLK_W'(busy), 0);
    repeat (15) step();
    check("t5_out_beats", BLK_W'(out_cnt), 0);
    check("t5_done_cycles", BLK_W'(done_cnt), 0);
    check("t5_busy_idle", BLK_W'(busy), 0);
    check("t5_blocks_done", BLK_W'(blocks_done), 0);

    // Second start during LOAD must not disturb the running job
    clear_counts();
    core_lat = 2;
    start_job(32'd16);
    for (int n = 0; n < 50 && !bus.in_ready_o; n++) step();
    check("t6_in_load", BLK_W'(bus.in_ready_o), 1);
    data_len = 32'd64;
    start    = 1'b1;
    step();
    start    = 1'b0;
    exp_w[0] = 32'hCAFE_BABE; exp_w[1] = 32'h1234_5678;
    exp_w[2] = 32'h9ABC_DEF0; exp_w[3] = 32'h0BAD_F00D;
    src_q = {exp_w[0], exp_w[1], exp_w[2], exp_w[3]};
    wait_done(200, "t6");
    repeat (3) step();
    check("t6_blocks_done", BLK_W'(blocks_done), 1);
    check("t6_start_pulses", BLK_W'(start_cnt), 1);
    check("t6_done_cycles", BLK_W'(done_cnt), 1);
    check("t6_words_in", BLK_W'(in_cnt), 4);
    check_out("t6", 4);
    check("t6_busy_idle", BLK_W'(busy), 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
